// File: rtl/register_file_pkg.sv
// Shared constants, state encoding and helpers for the 64-bit architectural
// register file and its read ports.
package register_file_pkg;

  localparam int unsigned N      = 64;        // data width of every register and bus
  localparam int unsigned NREG   = 32;        // architectural register count
  localparam int unsigned NSTORE = NREG - 1;  // X31 is not stored

  localparam logic [4:0]  XZR          = 5'd31;          // hard-wired zero register
  localparam logic [4:0]  SWEEP_LAST   = 5'd30;          // last index cleared by the sweep
  localparam logic [31:0] WR_COUNT_MAX = 32'hFFFF_FFFF;  // saturation value of WrCount

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Saturating increment for the committed-write counter
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == WR_COUNT_MAX) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: XZR forcing, zero during the clear sweep,
// same-cycle write bypass, otherwise the stored value.
module regfile_read_port
  import register_file_pkg::*;
(
  input  logic [4:0]              sel,
  input  state_t                  state,
  input  logic                    wr_en,
  input  logic [4:0]              wr_idx,
  input  logic [N-1:0]            wr_data,
  input  logic [NSTORE-1:0][N-1:0] regs,
  output logic [N-1:0]            data
);

  // Priority read mux; the XZR test comes first so regs is never indexed with 31
  always_comb begin
    data = {N{1'b0}};
    if (sel == XZR) begin
      data = {N{1'b0}};
    end else if (state == CLEAR) begin
      data = {N{1'b0}};
    end else if (wr_en && (wr_idx == sel)) begin
      data = wr_data;
    end else begin
      data = regs[sel];
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file: 31 stored 64-bit registers plus XZR, a
// post-reset clear sweep gating Ready, saturating committed-write counter
// and two bypassing combinational read ports.
module register_file
  import register_file_pkg::*;
(
  input  logic         CLK,
  input  logic         Reset,
  input  logic [4:0]   RA,
  input  logic [4:0]   RB,
  input  logic [4:0]   RW,
  input  logic         RegWr,
  input  logic [N-1:0] BusW,
  output logic [N-1:0] BusA,
  output logic [N-1:0] BusB,
  output logic         Ready,
  output logic [31:0]  WrCount
);

  state_t                   state_r;
  state_t                   next_state_s;
  logic [4:0]               cnt_r;
  logic                     ready_r;
  logic [31:0]              wr_count_r;
  logic [NSTORE-1:0][N-1:0] regs_r;
  logic                     clear_s;
  logic                     commit_s;

  // State register; Ready is registered alongside so it rises with RUN
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= CLEAR;
      ready_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s == RUN);
    end
  end

  // Next state: leave CLEAR on the edge that zeroes the last stored register
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      CLEAR: begin
        if (cnt_r == SWEEP_LAST) begin
          next_state_s = RUN;
        end else begin
          next_state_s = CLEAR;
        end
      end
      RUN:     next_state_s = RUN;
      default: next_state_s = CLEAR;
    endcase
  end

  // Control decode: sweep clears in CLEAR, writes commit only in RUN and never to XZR
  always_comb begin
    clear_s  = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      CLEAR: begin
        clear_s  = 1'b1;
        commit_s = 1'b0;
      end
      RUN: begin
        clear_s  = 1'b0;
        commit_s = RegWr && (RW != XZR);
      end
      default: begin
        clear_s  = 1'b0;
        commit_s = 1'b0;
      end
    endcase
  end

  // Sweep counter: restarts at X0 on every reset, steps once per CLEAR cycle
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt_r <= 5'd0;
    end else if (clear_s) begin
      cnt_r <= cnt_r + 5'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Register array: reset drops any write; sweep zeroes one entry per cycle
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      if (clear_s) begin
        regs_r[cnt_r] <= {N{1'b0}};
      end else if (commit_s) begin
        regs_r[RW] <= BusW;
      end
    end
  end

  // Committed-write counter, saturating at all-ones
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_count_r <= 32'd0;
    end else if (commit_s) begin
      wr_count_r <= sat_inc32(wr_count_r);
    end else begin
      wr_count_r <= wr_count_r;
    end
  end

  regfile_read_port u_port_a (
    .sel     (RA),
    .state   (state_r),
    .wr_en   (RegWr),
    .wr_idx  (RW),
    .wr_data (BusW),
    .regs    (regs_r),
    .data    (BusA)
  );

  regfile_read_port u_port_b (
    .sel     (RB),
    .state   (state_r),
    .wr_en   (RegWr),
    .wr_idx  (RW),
    .wr_data (BusW),
    .regs    (regs_r),
    .data    (BusB)
  );

  assign Ready   = ready_r;
  assign WrCount = wr_count_r;

endmodule
